linebuffer_ctrl: RTL and testbench

LINEBUFFER_CTRL -- requirements
Module: linebuffer_ctrl

---
 rtl/linebuffer_ctrl.sv | 147 ++++++++++++++
 tb/tb_linebuffer_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_ctrl.sv
// Double-banked linebuffer controller: one bank is cleared as it is displayed,
// the other is written by the sprite renderer; the two banks swap on every line start.
module linebuffer_ctrl (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pix_en,
    input  logic       i_line_start,
    input  logic       i_spr_load,
    input  logic [7:0] i_spr_x,
    input  logic       i_spr_pix_valid,
    input  logic       i_spr_pix_opaque,
    output logic       o_spr_ready,
    output logic [1:0] o_lb_ck,
    output logic [1:0] o_lb_load,
    output logic [1:0] o_lb_we,
    output logic [1:0] o_lb_clearing,
    output logic [7:0] o_lb_addr_load0,
    output logic [7:0] o_lb_addr_load1,
    output logic       o_out_sel,
    output logic       o_overrun
);

    typedef enum logic [2:0] {D_IDLE, D_RELOAD, D_WAIT, D_CLEAR, D_ADV, D_DONE} dstate_t;
    typedef enum logic [1:0] {R_IDLE, R_RELOAD, R_WRITE, R_ADV} rstate_t;

    dstate_t    r_dstate;
    rstate_t    r_rstate;
    logic       r_out_sel;
    logic       r_overrun;
    logic [1:0] r_lb_ck;
    logic [1:0] r_lb_load;
    logic [1:0] r_lb_we;
    logic [1:0] r_lb_clearing;
    logic [7:0] r_addr_load [2];
    logic [7:0] r_shadow [2];

    logic w_dbank;
    logic w_rbank;

    assign w_dbank = r_out_sel;
    assign w_rbank = ~r_out_sel;

    // Ready is blanked combinationally in the line-start cycle so no request is taken across a swap.
    assign o_spr_ready     = (r_rstate == R_IDLE) && !i_line_start;
    assign o_lb_ck         = r_lb_ck;
    assign o_lb_load       = r_lb_load;
    assign o_lb_we         = r_lb_we;
    assign o_lb_clearing   = r_lb_clearing;
    assign o_lb_addr_load0 = r_addr_load[0];
    assign o_lb_addr_load1 = r_addr_load[1];
    assign o_out_sel       = r_out_sel;
    assign o_overrun       = r_overrun;

    // Bank controls are registered: each transition drives the strobes for the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dstate       <= D_IDLE;
            r_rstate       <= R_IDLE;
            r_out_sel      <= 1'b0;
            r_overrun      <= 1'b0;
            r_lb_ck        <= 2'b00;
            r_lb_load      <= 2'b11;
            r_lb_we        <= 2'b11;
            r_lb_clearing  <= 2'b00;
            r_addr_load[0] <= 8'd0;
            r_addr_load[1] <= 8'd0;
            r_shadow[0]    <= 8'd0;
            r_shadow[1]    <= 8'd0;
        end else begin
            r_lb_ck       <= 2'b00;
            r_lb_load     <= 2'b11;
            r_lb_we       <= 2'b11;
            r_lb_clearing <= 2'b00;
            r_overrun     <= 1'b0;

            if (i_line_start) begin
                r_out_sel              <= ~r_out_sel;
                r_dstate               <= D_RELOAD;
                r_lb_ck[~r_out_sel]    <= 1'b1;
                r_lb_load[~r_out_sel]  <= 1'b0;
                r_addr_load[~r_out_sel] <= 8'd0;
            end else begin
                case (r_dstate)
                    D_RELOAD: begin
                        r_shadow[w_dbank] <= 8'd0;
                        r_dstate          <= D_WAIT;
                    end
                    D_WAIT: begin
                        if (i_pix_en) begin
                            r_dstate               <= D_CLEAR;
                            r_lb_we[w_dbank]       <= 1'b0;
                            r_lb_clearing[w_dbank] <= 1'b1;
                        end
                    end
                    D_CLEAR: begin
                        r_dstate         <= D_ADV;
                        r_lb_ck[w_dbank] <= 1'b1;
                    end
                    D_ADV: begin
                        r_shadow[w_dbank] <= r_shadow[w_dbank] + 8'd1;
                        r_dstate          <= (r_shadow[w_dbank] == 8'd191) ? D_DONE : D_WAIT;
                    end
                    default: ;
                endcase
            end

            if (i_line_start) begin
                if (r_rstate != R_IDLE)
                    r_overrun <= 1'b1;
                r_rstate <= R_IDLE;
            end else begin
                case (r_rstate)
                    R_IDLE: begin
                        if (i_spr_load) begin
                            r_rstate             <= R_RELOAD;
                            r_lb_ck[w_rbank]     <= 1'b1;
                            r_lb_load[w_rbank]   <= 1'b0;
                            r_addr_load[w_rbank] <= i_spr_x;
                        end else if (i_spr_pix_valid) begin
                            // Pixels past the visible 192 still advance the counter but never write.
                            if (i_spr_pix_opaque && (r_shadow[w_rbank] < 8'd192)) begin
                                r_rstate         <= R_WRITE;
                                r_lb_we[w_rbank] <= 1'b0;
                            end else begin
                                r_rstate         <= R_ADV;
                                r_lb_ck[w_rbank] <= 1'b1;
                            end
                        end
                    end
                    R_RELOAD: begin
                        r_shadow[w_rbank] <= r_addr_load[w_rbank];
                        r_rstate          <= R_IDLE;
                    end
                    R_WRITE: begin
                        r_rstate         <= R_ADV;
                        r_lb_ck[w_rbank] <= 1'b1;
                    end
                    default: begin
                        r_shadow[w_rbank] <= r_shadow[w_rbank] + 8'd1;
                        r_rstate          <= R_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl: a bus monitor mirrors each bank's address counter,
// logs every write and flags write-strobe timing violations.
module tb_linebuffer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       line_start = 1'b0;
    logic       spr_load = 1'b0;
    logic [7:0] spr_x = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_opaque = 1'b0;
    logic       spr_ready;
    logic [1:0] lb_ck, lb_load, lb_we, lb_clearing;
    logic [7:0] addr0, addr1;
    logic       out_sel, overrun;

    int n_checks = 0;
    int n_err = 0;

    int         n_reload [2];
    int         n_inc [2];
    int         n_viol = 0;
    logic [7:0] m_addr [2];
    logic [1:0] p_ck = 2'b00;
    logic [1:0] p_we = 2'b11;
    int         wr_log [$];

    always #5 clk = ~clk;

    linebuffer_ctrl dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_pix_en        (pix_en),
        .i_line_start    (line_start),
        .i_spr_load      (spr_load),
        .i_spr_x         (spr_x),
        .i_spr_pix_valid (pix_valid),
        .i_spr_pix_opaque(pix_opaque),
        .o_spr_ready     (spr_ready),
        .o_lb_ck         (lb_ck),
        .o_lb_load       (lb_load),
        .o_lb_we         (lb_we),
        .o_lb_clearing   (lb_clearing),
        .o_lb_addr_load0 (addr0),
        .o_lb_addr_load1 (addr1),
        .o_out_sel       (out_sel),
        .o_overrun       (overrun)
    );

    // Log entry encoding: bank*1024 + clearing*512 + address.
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!reset) begin
                if (!lb_we[b]) begin
                    wr_log.push_back(b * 1024 + (lb_clearing[b] ? 512 : 0) + int'(m_addr[b]));
                    if (lb_ck[b] || p_ck[b] || !p_we[b])
                        n_viol <= n_viol + 1;
                end
                if (lb_clearing[b] && (b != int'(out_sel)))
                    n_viol <= n_viol + 1;
                if (lb_ck[b] && !lb_load[b]) begin
                    n_reload[b] <= n_reload[b] + 1;
                    m_addr[b]   <= (b == 0) ? addr0 : addr1;
                end
                if (lb_ck[b] && lb_load[b]) begin
                    n_inc[b]  <= n_inc[b] + 1;
                    m_addr[b] <= m_addr[b] + 8'd1;
                end
            end
        end
        p_ck <= lb_ck;
        p_we <= lb_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic opaque);
        pix_valid  = 1'b1;
        pix_opaque = opaque;
        step();
        pix_valid  = 1'b0;
        pix_opaque = 1'b0;
        step();
        step();
    endtask

    task automatic sprite_load(input logic [7:0] x);
        spr_x    = x;
        spr_load = 1'b1;
        step();
        spr_load = 1'b0;
    endtask

    task automatic test_reset();
        int s_ops, s_wr;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (out_sel !== 1'b0) begin n_err++; $display("FAIL reset_out_sel: got %0b want 0", out_sel); end
        n_checks++;
        if (spr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", spr_ready); end
        n_checks++;
        if ({lb_ck, lb_load, lb_we, lb_clearing} !== 8'b00_11_11_00) begin
            n_err++; $display("FAIL reset_bank_ctl: got %b want 00111100", {lb_ck, lb_load, lb_we, lb_clearing});
        end
        n_checks++;
        if ({addr0, addr1, overrun} !== 17'd0) begin
            n_err++; $display("FAIL reset_addr_ovr: got %0h %0h %0b want 0 0 0", addr0, addr1, overrun);
        end
        reset = 1'b0;
        step();
        s_ops = n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1];
        s_wr  = wr_log.size();
        for (int i = 0; i < 3; i++) begin
            pix_en = 1'b1; step(); pix_en = 1'b0; step(); step(); step();
        end
        n_checks++;
        if ((n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1] - s_ops) !== 0 || (wr_log.size() - s_wr) !== 0) begin
            n_err++; $display("FAIL idle_before_line: got ops=%0d writes=%0d want 0 0",
                              n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1] - s_ops, wr_log.size() - s_wr);
        end
    endtask

    task automatic test_display_line();
        int s_rl, s_inc, s_wr, bad;
        s_rl  = n_reload[1];
        s_inc = n_inc[1];
        s_wr  = wr_log.size();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        n_checks++;
        if (out_sel !== 1'b1) begin n_err++; $display("FAIL line_out_sel: got %0b want 1", out_sel); end
        n_checks++;
        if ({lb_ck[1], lb_load[1], addr1} !== {1'b1, 1'b0, 8'd0}) begin
            n_err++; $display("FAIL line_reload: got ck=%0b load=%0b addr=%0d want 1 0 0", lb_ck[1], lb_load[1], addr1);
        end
        step();
        for (int i = 0; i < 192; i++) begin
            pix_en = 1'b1; step(); pix_en = 1'b0; step(); step(); step();
        end
        pix_en = 1'b1; step(); pix_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if ((n_reload[1] - s_rl) !== 1) begin n_err++; $display("FAIL line_reload_cnt: got %0d want 1", n_reload[1] - s_rl); end
        n_checks++;
        if ((n_inc[1] - s_inc) !== 192) begin n_err++; $display("FAIL line_inc_cnt: got %0d want 192", n_inc[1] - s_inc); end
        n_checks++;
        if ((wr_log.size() - s_wr) !== 192) begin n_err++; $display("FAIL line_clear_cnt: got %0d want 192", wr_log.size() - s_wr); end
        bad = 0;
        for (int i = 0; i < 192 && (s_wr + i) < wr_log.size(); i++)
            if (wr_log[s_wr + i] != 1024 + 512 + i) bad++;
        n_checks++;
        if (bad !== 0) begin n_err++; $display("FAIL line_clear_addr: got %0d bad entries want 0", bad); end
        n_checks++;
        if (m_addr[1] !== 8'd192) begin n_err++; $display("FAIL line_end_addr: got %0d want 192", m_addr[1]); end
    endtask

    task automatic test_sprite_basic();
        int s_wr, low;
        s_wr = wr_log.size();
        sprite_load(8'd10);
        n_checks++;
        if ({lb_ck, lb_load[0], addr0, spr_ready} !== {2'b01, 1'b0, 8'd10, 1'b0}) begin
            n_err++; $display("FAIL spr_reload: got ck=%b load0=%0b addr0=%0d rdy=%0b want 01 0 10 0",
                              lb_ck, lb_load[0], addr0, spr_ready);
        end
        step();
        low = 0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_opaque = 1'b1; step(); pix_valid = 1'b0;
            if (!spr_ready) low++;
            step();
            if (!spr_ready) low++;
            step();
        end
        step();
        n_checks++;
        if (low !== 6) begin n_err++; $display("FAIL spr_ready_low: got %0d cycles want 6", low); end
        n_checks++;
        if ((wr_log.size() - s_wr) !== 3) begin
            n_err++; $display("FAIL spr_wr_cnt: got %0d want 3", wr_log.size() - s_wr);
        end else begin
            n_checks++;
            if ({wr_log[s_wr], wr_log[s_wr + 1], wr_log[s_wr + 2]} !== {32'd10, 32'd11, 32'd12}) begin
                n_err++; $display("FAIL spr_wr_addr: got %0d %0d %0d want 10 11 12",
                                  wr_log[s_wr], wr_log[s_wr + 1], wr_log[s_wr + 2]);
            end
        end
        n_checks++;
        if (dut.r_shadow[0] !== 8'd13) begin n_err++; $display("FAIL spr_shadow: got %0d want 13", dut.r_shadow[0]); end
    endtask

    task automatic test_sprite_edge();
        int s_wr, s_inc;
        s_wr  = wr_log.size();
        s_inc = n_inc[0];
        sprite_load(8'd190);
        step();
        for (int i = 0; i < 4; i++) pixel(1'b1);
        step();
        n_checks++;
        if ((wr_log.size() - s_wr) !== 2) begin
            n_err++; $display("FAIL edge_wr_cnt: got %0d want 2", wr_log.size() - s_wr);
        end else begin
            n_checks++;
            if ({wr_log[s_wr], wr_log[s_wr + 1]} !== {32'd190, 32'd191}) begin
                n_err++; $display("FAIL edge_wr_addr: got %0d %0d want 190 191", wr_log[s_wr], wr_log[s_wr + 1]);
            end
        end
        n_checks++;
        if ((n_inc[0] - s_inc) !== 4) begin n_err++; $display("FAIL edge_inc_cnt: got %0d want 4", n_inc[0] - s_inc); end
        n_checks++;
        if (m_addr[0] !== 8'd194) begin n_err++; $display("FAIL edge_end_addr: got %0d want 194", m_addr[0]); end
    endtask

    task automatic test_wrap();
        int s_wr;
        s_wr = wr_log.size();
        sprite_load(8'd255);
        step();
        pixel(1'b0);
        step();
        n_checks++;
        if ((wr_log.size() - s_wr) !== 0) begin n_err++; $display("FAIL wrap_no_write: got %0d writes want 0", wr_log.size() - s_wr); end
        n_checks++;
        if (dut.r_shadow[0] !== 8'd0) begin n_err++; $display("FAIL wrap_shadow: got %0d want 0", dut.r_shadow[0]); end
        pixel(1'b1);
        step();
        n_checks++;
        if ((wr_log.size() - s_wr) !== 1) begin
            n_err++; $display("FAIL wrap_write_cnt: got %0d want 1", wr_log.size() - s_wr);
        end else begin
            n_checks++;
            if (wr_log[s_wr] !== 0) begin n_err++; $display("FAIL wrap_write_addr: got %0d want 0", wr_log[s_wr]); end
        end
    endtask

    task automatic test_overrun();
        int s_wr;
        sprite_load(8'd20);
        step();
        pix_valid = 1'b1; pix_opaque = 1'b1; step(); pix_valid = 1'b0; pix_opaque = 1'b0;
        n_checks++;
        if (lb_we !== 2'b10) begin n_err++; $display("FAIL ovr_pre_write: got we=%b want 10", lb_we); end
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        n_checks++;
        if ({overrun, out_sel} !== 2'b10) begin n_err++; $display("FAIL ovr_pulse: got ovr=%0b sel=%0b want 1 0", overrun, out_sel); end
        n_checks++;
        if ({lb_ck, lb_load[0], addr0, lb_we} !== {2'b01, 1'b0, 8'd0, 2'b11}) begin
            n_err++; $display("FAIL ovr_disp_reload: got ck=%b load0=%0b addr0=%0d we=%b want 01 0 0 11",
                              lb_ck, lb_load[0], addr0, lb_we);
        end
        s_wr = wr_log.size();
        line_start = 1'b1;
        #1;
        n_checks++;
        if (spr_ready !== 1'b0) begin n_err++; $display("FAIL ready_in_line_start: got %0b want 0", spr_ready); end
        line_start = 1'b0;
        #1;
        step();
        n_checks++;
        if ({overrun, spr_ready} !== 2'b01) begin n_err++; $display("FAIL ovr_one_cycle: got ovr=%0b rdy=%0b want 0 1", overrun, spr_ready); end
        pix_en = 1'b1; step(); pix_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if ((wr_log.size() - s_wr) !== 1) begin
            n_err++; $display("FAIL ovr_wr_cnt: got %0d want 1", wr_log.size() - s_wr);
        end else begin
            n_checks++;
            if (wr_log[s_wr] !== 512) begin n_err++; $display("FAIL ovr_restart_clear: got %0d want 512", wr_log[s_wr]); end
        end
    endtask

    task automatic test_reset_mid();
        int s_ops, s_wr;
        pix_en = 1'b1; step(); pix_en = 1'b0;
        n_checks++;
        if ({lb_we, lb_clearing} !== 4'b10_01) begin
            n_err++; $display("FAIL rst_pre_clear: got we=%b clr=%b want 10 01", lb_we, lb_clearing);
        end
        reset = 1'b1; line_start = 1'b1; spr_load = 1'b1; spr_x = 8'd5;
        step();
        n_checks++;
        if ({lb_ck, lb_load, lb_we, lb_clearing, out_sel} !== 9'b00_11_11_00_0) begin
            n_err++; $display("FAIL rst_mid_ctl: got %b want 001111000", {lb_ck, lb_load, lb_we, lb_clearing, out_sel});
        end
        n_checks++;
        if ({addr0, addr1, overrun} !== 17'd0) begin
            n_err++; $display("FAIL rst_mid_addr: got %0d %0d %0b want 0 0 0", addr0, addr1, overrun);
        end
        line_start = 1'b0; spr_load = 1'b0;
        #1;
        n_checks++;
        if (spr_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0b want 1", spr_ready); end
        reset = 1'b0;
        step();
        s_ops = n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1];
        s_wr  = wr_log.size();
        pix_en = 1'b1; step(); pix_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if ((n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1] - s_ops) !== 0 || (wr_log.size() - s_wr) !== 0 || out_sel !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_idle: got ops=%0d writes=%0d sel=%0b want 0 0 0",
                              n_reload[0] + n_reload[1] + n_inc[0] + n_inc[1] - s_ops, wr_log.size() - s_wr, out_sel);
        end
    endtask

    initial begin
        n_reload[0] = 0; n_reload[1] = 0;
        n_inc[0] = 0;    n_inc[1] = 0;
        test_reset();
        test_display_line();
        test_sprite_basic();
        test_sprite_edge();
        test_wrap();
        test_overrun();
        test_reset_mid();
        n_checks++;
        if (n_viol !== 0) begin n_err++; $display("FAIL we_timing: got %0d violations want 0", n_viol); end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
